fpga_tile_cfg: RTL and testbench

- Parametrised next-generation logic tile: W-track routing channel per side, K-input LUT with optional output register, and per-track output muxes.
- Configuration is loaded serially through a daisy-chainable scan chain into a shadow register, then atomically committed to the active configuration (double-buffered).
- Instantiated in a grid by the array top level; cfg_dout of one tile feeds cfg_din of the next.

---
 rtl/fpga_tile_cfg.sv | 178 +++++++++++++++++
 tb/tb_fpga_tile_cfg.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_tile_cfg.sv
// Logic tile: K-input LUT with optional output FF, per-track output muxes,
// and a double-buffered serial configuration chain (shadow -> active).
module fpga_tile_cfg #(
    parameter int W = 4,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] north_in,
    input  logic [W-1:0] east_in,
    input  logic [W-1:0] south_in,
    input  logic [W-1:0] west_in,
    output logic [W-1:0] north_out,
    output logic [W-1:0] east_out,
    output logic [W-1:0] south_out,
    output logic [W-1:0] west_out,
    input  logic         cfg_en,
    input  logic         cfg_din,
    output logic         cfg_dout,
    input  logic         cfg_commit,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         configured
);

    localparam int NT        = 4 * W;
    localparam int SELW      = $clog2(NT);
    localparam int LUTN      = 2 ** K;
    localparam int CFG_LEN   = LUTN + 1 + K * SELW + 8 * W;
    localparam int SEL_BASE  = LUTN + 1;
    localparam int MODE_BASE = SEL_BASE + K * SELW;
    localparam int CNTW      = $clog2(CFG_LEN + 2);

    typedef enum logic {ST_UNCONFIG, ST_ACTIVE} state_t;

    state_t              state_reg, state_next;
    logic [CFG_LEN-1:0]  shadow_reg;
    logic [CFG_LEN-1:0]  active_reg;
    logic [CNTW-1:0]     cnt_reg;
    logic                ff_reg;
    logic                err_reg;

    logic                commit_ok;
    logic                commit_bad;
    logic [NT-1:0]       tin;
    logic [NT-1:0]       tout;
    logic [K-1:0]        lut_in;
    logic [LUTN-1:0]     truth;
    logic                use_ff;
    logic                lut_out;
    logic                clb_out;

    assign commit_ok  = cfg_commit && !cfg_en && (cnt_reg == CNTW'(CFG_LEN));
    assign commit_bad = cfg_commit && !commit_ok;

    assign cfg_dout  = shadow_reg[0];
    assign cfg_ready = (cnt_reg == CNTW'(CFG_LEN));
    assign cfg_err   = err_reg;

    // Serial shift into the shadow register; first bit in ends up at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else if (cfg_en) begin
            shadow_reg <= {cfg_din, shadow_reg[CFG_LEN-1:1]};
        end
    end

    // Bit counter: cleared by a good commit, saturates one past CFG_LEN so
    // over-shifting is remembered; a rejected commit leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (commit_ok) begin
            cnt_reg <= '0;
        end else if (cfg_en && !cfg_commit && (cnt_reg != CNTW'(CFG_LEN + 1))) begin
            cnt_reg <= cnt_reg + CNTW'(1);
        end
    end

    // Atomic copy of the shadow into the active configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= '0;
        end else if (commit_ok) begin
            active_reg <= shadow_reg;
        end
    end

    // Sticky error flag for any rejected commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (commit_bad) begin
            err_reg <= 1'b1;
        end
    end

    // LUT output register; held at 0 until the tile is configured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_reg <= 1'b0;
        end else begin
            ff_reg <= configured ? lut_out : 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_UNCONFIG;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: only a good commit moves forward; only reset goes back.
    always_comb begin
        state_next = state_reg;
        if (commit_ok) begin
            state_next = ST_ACTIVE;
        end
    end

    // FSM outputs.
    always_comb begin
        configured = (state_reg == ST_ACTIVE);
    end

    assign tin    = {west_in, south_in, east_in, north_in};
    assign truth  = active_reg[LUTN-1:0];
    assign use_ff = active_reg[LUTN];

    // LUT input selection; out-of-range selects feed a constant 0.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_lut_in
            logic [SELW-1:0] sel;
            assign sel        = active_reg[SEL_BASE + gi * SELW +: SELW];
            assign lut_in[gi] = ({1'b0, sel} < (SELW + 1)'(NT)) ? tin[sel] : 1'b0;
        end
    endgenerate

    assign lut_out = truth[lut_in];
    assign clb_out = use_ff ? ff_reg : lut_out;

    // Per-track output mux. Sides are N=0, E=1, S=2, W=3 in tin/tout order.
    generate
        for (gi = 0; gi < NT; gi++) begin : g_out
            localparam int SIDE = gi / W;
            localparam int TRK  = gi % W;
            localparam int OPP  = ((SIDE + 2) % 4) * W + TRK;
            localparam int CWN  = ((SIDE + 3) % 4) * W + TRK;
            logic [1:0] mode;
            logic       t_out;
            assign mode = active_reg[MODE_BASE + 2 * gi +: 2];
            // Select drive source for this track, forced low when unconfigured.
            always_comb begin
                t_out = 1'b0;
                if (configured) begin
                    case (mode)
                        2'b01:   t_out = clb_out;
                        2'b10:   t_out = tin[OPP];
                        2'b11:   t_out = tin[CWN];
                        default: t_out = 1'b0;
                    endcase
                end
            end
            assign tout[gi] = t_out;
        end
    endgenerate

    assign north_out = tout[W-1:0];
    assign east_out  = tout[2*W-1:W];
    assign south_out = tout[3*W-1:2*W];
    assign west_out  = tout[4*W-1:3*W];

endmodule

// File: tb/tb_fpga_tile_cfg.sv
// Scoreboard bench for fpga_tile_cfg: two chained tiles (A.cfg_dout -> B.cfg_din).
module tb_fpga_tile_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] a_north_in = '0, a_east_in = '0, a_south_in = '0, a_west_in = '0;
    logic [3:0] a_north_out, a_east_out, a_south_out, a_west_out;
    logic       a_en = 1'b0, a_din = 1'b0, a_commit = 1'b0;
    logic       a_dout, a_ready, a_err, a_configured;

    logic [3:0] b_north_in = '0, b_east_in = '0, b_south_in = '0, b_west_in = '0;
    logic [3:0] b_north_out, b_east_out, b_south_out, b_west_out;
    logic       b_en = 1'b0, b_commit = 1'b0;
    logic       b_dout, b_ready, b_err, b_configured;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int          code;
        logic [15:0] exp;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    fpga_tile_cfg #(.W(4), .K(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .north_in(a_north_in), .east_in(a_east_in), .south_in(a_south_in), .west_in(a_west_in),
        .north_out(a_north_out), .east_out(a_east_out), .south_out(a_south_out), .west_out(a_west_out),
        .cfg_en(a_en), .cfg_din(a_din), .cfg_dout(a_dout), .cfg_commit(a_commit),
        .cfg_ready(a_ready), .cfg_err(a_err), .configured(a_configured)
    );

    fpga_tile_cfg #(.W(4), .K(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .north_in(b_north_in), .east_in(b_east_in), .south_in(b_south_in), .west_in(b_west_in),
        .north_out(b_north_out), .east_out(b_east_out), .south_out(b_south_out), .west_out(b_west_out),
        .cfg_en(b_en), .cfg_din(a_dout), .cfg_dout(b_dout), .cfg_commit(b_commit),
        .cfg_ready(b_ready), .cfg_err(b_err), .configured(b_configured)
    );

    // Config word: {modes[31:0], sels (sel3..sel0), use_ff, truth[15:0]}.
    function automatic logic [64:0] make_cfg(input logic [15:0] truth, input logic use_ff,
                                              input logic [15:0] sels, input logic [31:0] modes);
        return {modes, sels, use_ff, truth};
    endfunction

    // Monitor: at every falling edge, compare all pending expectations.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        it;
            logic [15:0] act;
            it = exp_q.pop_front();
            case (it.code)
                0:       act = {a_west_out, a_south_out, a_east_out, a_north_out};
                1:       act = {13'd0, a_ready, a_err, a_configured};
                2:       act = {b_west_out, b_south_out, b_east_out, b_north_out};
                3:       act = {13'd0, b_ready, b_err, b_configured};
                default: act = {14'd0, a_err, a_configured};
            endcase
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", it.name, act, it.exp);
            end else begin
                $display("ok   %s value=%h", it.name, act);
            end
        end
    end

    task automatic expect_val(input string n, input int c, input logic [15:0] e);
        exp_t it;
        it.name = n;
        it.code = c;
        it.exp  = e;
        exp_q.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_a(input logic [64:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            a_en  = 1'b1;
            a_din = v[i];
            tick();
        end
        a_en  = 1'b0;
        a_din = 1'b0;
    endtask

    task automatic commit_a();
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [64:0] c1, c2, c3;
        c1 = make_cfg(16'h8000, 1'b0, 16'h3210, 32'h5555_5555);
        c2 = make_cfg(16'h8000, 1'b1, 16'h3210, 32'h5555_5555);
        c3 = make_cfg(16'h0000, 1'b0, 16'h3210, 32'h0000_FFAA);

        // Reset state and unconfigured gating.
        tick();
        a_north_in = 4'hF;
        expect_val("rst_out", 0, 16'h0000);
        expect_val("rst_flags", 1, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        expect_val("nocfg_out", 0, 16'h0000);
        expect_val("nocfg_flags", 1, 16'h0000);
        tick();

        // AND4 configuration, combinational path.
        shift_a(c1, 65);
        expect_val("c1_ready", 1, 16'h0004);
        tick();
        commit_a();
        expect_val("c1_flags", 1, 16'h0001);
        expect_val("c1_and_hi", 0, 16'hFFFF);
        tick();
        a_north_in = 4'h7;
        expect_val("c1_and_lo", 0, 16'h0000);
        tick();

        // Shifting while active leaves outputs alone; then route modes.
        a_north_in = 4'hF;
        a_south_in = 4'hA;
        shift_a(c3, 65);
        expect_val("active_isolated", 0, 16'hFFFF);
        expect_val("c3_ready", 1, 16'h0005);
        tick();
        commit_a();
        a_north_in = 4'h5;
        expect_val("modes_a5", 0, 16'h005A);
        tick();
        a_north_in = 4'h9;
        a_south_in = 4'h3;
        expect_val("modes_93", 0, 16'h0093);
        tick();

        // Registered LUT output lags by one clock.
        a_south_in = 4'h0;
        a_north_in = 4'h7;
        shift_a(c2, 65);
        commit_a();
        a_north_in = 4'hF;
        expect_val("ff_lag0", 0, 16'h0000);
        tick();
        a_north_in = 4'h7;
        expect_val("ff_rise", 0, 16'hFFFF);
        tick();
        expect_val("ff_fall", 0, 16'h0000);
        tick();

        // Short shift then commit.
        do_reset();
        a_north_in = 4'hF;
        shift_a(c1, 64);
        expect_val("short_ready", 1, 16'h0000);
        tick();
        commit_a();
        expect_val("short_commit", 1, 16'h0002);
        expect_val("short_out", 0, 16'h0000);
        tick();

        // Over-shift then commit.
        do_reset();
        shift_a(c1, 65);
        expect_val("exact_ready", 1, 16'h0004);
        tick();
        shift_a(c1, 1);
        expect_val("over_ready", 1, 16'h0000);
        tick();
        commit_a();
        expect_val("over_commit", 1, 16'h0002);
        tick();

        // Commit coinciding with shift enable.
        do_reset();
        shift_a(c1, 65);
        a_en     = 1'b1;
        a_commit = 1'b1;
        tick();
        a_en     = 1'b0;
        a_commit = 1'b0;
        expect_val("en_commit", 4, 16'h0002);
        tick();

        // Two-tile chain: B gets bits 1..65 (c3), A gets bits 66..130 (c1).
        do_reset();
        a_north_in = 4'hF;
        b_south_in = 4'hA;
        b_north_in = 4'h5;
        shift_a(c3, 65);
        commit_a();
        for (int i = 0; i < 65; i++) begin
            a_en  = 1'b1;
            b_en  = 1'b1;
            a_din = c1[i];
            tick();
        end
        a_en  = 1'b0;
        b_en  = 1'b0;
        a_din = 1'b0;
        expect_val("chain_a_ready", 1, 16'h0005);
        expect_val("chain_b_ready", 3, 16'h0004);
        tick();
        a_commit = 1'b1;
        b_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        b_commit = 1'b0;
        expect_val("chain_a_out", 0, 16'hFFFF);
        expect_val("chain_b_out", 2, 16'h005A);
        expect_val("chain_b_flags", 3, 16'h0001);
        tick();

        // Reset asserted in the middle of a shift.
        shift_a(c3, 30);
        a_en  = 1'b1;
        a_din = 1'b1;
        rst_n = 1'b0;
        expect_val("midrst_a_out", 0, 16'h0000);
        expect_val("midrst_a_flags", 1, 16'h0000);
        expect_val("midrst_b_out", 2, 16'h0000);
        tick();
        a_en  = 1'b0;
        a_din = 1'b0;
        rst_n = 1'b1;
        tick();
        shift_a(c1, 64);
        expect_val("midrst_cnt64", 1, 16'h0000);
        tick();
        shift_a(c1, 1);
        expect_val("midrst_cnt65", 1, 16'h0004);
        expect_val("midrst_unconf", 0, 16'h0000);
        tick();
        tick();

        @(negedge clk);
        #1;

        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL final_a_ready actual=%b required=1", a_ready);
        end else begin
            $display("ok   final_a_ready value=%b", a_ready);
        end
        checks++;
        if (a_configured !== 1'b0) begin
            failures++;
            $display("FAIL final_a_configured actual=%b required=0", a_configured);
        end else begin
            $display("ok   final_a_configured value=%b", a_configured);
        end
        checks++;
        if (a_err !== 1'b0) begin
            failures++;
            $display("FAIL final_a_err actual=%b required=0", a_err);
        end else begin
            $display("ok   final_a_err value=%b", a_err);
        end
        checks++;
        if (b_configured !== 1'b0) begin
            failures++;
            $display("FAIL final_b_configured actual=%b required=0", b_configured);
        end else begin
            $display("ok   final_b_configured value=%b", b_configured);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
